// File: rtl/jtag_ir_dr_path.sv
// JTAG instruction register, decode, BYPASS/IDCODE data registers and registered TDO mux.
// Define JTAG_IDCODE_EN to build the IDCODE DR; otherwise reset selects BYPASS.
module jtag_ir_dr_path #(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [31:0]         IDCODE_VAL = 32'h1002_A0F1,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(8)
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                reset,
  input  logic                tdi,
  input  logic                captureIR,
  input  logic                shiftIR,
  input  logic                updateIR,
  input  logic                captureDR,
  input  logic                shiftDR,
  input  logic                updateDR,
  input  logic                select,
  input  logic                user_tdo,
  output logic                tdo,
  output logic [IR_WIDTH-1:0] instr,
  output logic                bypass_sel,
  output logic                idcode_sel,
  output logic                user_sel
);

  localparam logic [IR_WIDTH-1:0] OP_BYPASS  = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RST_INSTR = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RST_INSTR = OP_BYPASS;
`endif

  logic [IR_WIDTH-1:0] ir_shift;
  logic                bypass_reg;
  logic                idcode_bit;
  logic                tdo_mux;
  logic                any_reset;

  assign any_reset = !trst || !reset;

  // updateDR only matters to the external USER DR; keep it (and build-dependent parameters) referenced.
  logic unused_ok;
  assign unused_ok = updateDR ^ (^IDCODE_VAL) ^ (^OP_IDCODE);

  always_ff @(posedge tck) begin
    if (any_reset) begin
      ir_shift <= RST_INSTR;
      instr    <= RST_INSTR;
    end else begin
      if (captureIR)
        ir_shift <= IR_CAPTURE;
      else if (shiftIR)
        ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
      if (updateIR)
        instr <= ir_shift;
    end
  end

  always_comb begin
    user_sel = (instr == OP_USER);
`ifdef JTAG_IDCODE_EN
    idcode_sel = (instr == OP_IDCODE) && !user_sel;
`else
    idcode_sel = 1'b0;
`endif
    bypass_sel = !(user_sel || idcode_sel);
  end

  always_ff @(posedge tck) begin
    if (any_reset)
      bypass_reg <= 1'b0;
    else if (bypass_sel) begin
      if (captureDR)
        bypass_reg <= 1'b0;
      else if (shiftDR)
        bypass_reg <= tdi;
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] idcode_reg;

  // Shifting pushes TDI in from the top; the ID value does not recirculate.
  always_ff @(posedge tck) begin
    if (any_reset)
      idcode_reg <= IDCODE_VAL;
    else if (idcode_sel) begin
      if (captureDR)
        idcode_reg <= IDCODE_VAL;
      else if (shiftDR)
        idcode_reg <= {tdi, idcode_reg[31:1]};
    end
  end

  assign idcode_bit = idcode_reg[0];
`else
  assign idcode_bit = 1'b0;
`endif

  always_comb begin
    tdo_mux = bypass_reg;
    if (select)
      tdo_mux = ir_shift[0];
    else if (user_sel)
      tdo_mux = user_tdo;
    else if (idcode_sel)
      tdo_mux = idcode_bit;
  end

  always_ff @(negedge tck) begin
    if (!trst)
      tdo <= 1'b0;
    else if (shiftIR || shiftDR)
      tdo <= tdo_mux;
  end

endmodule

// File: tb/tb_jtag_ir_dr_path.sv
// Self-checking bench for jtag_ir_dr_path: decode table plus scoreboarded TDO streams.
// Follows JTAG_IDCODE_EN the same way the design does.
module tb_jtag_ir_dr_path;

  localparam logic [31:0] IDCODE_VAL = 32'h1002_A0F1;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] RST_INSTR = 4'h1;
  localparam bit         HAS_ID    = 1'b1;
`else
  localparam logic [3:0] RST_INSTR = 4'hF;
  localparam bit         HAS_ID    = 1'b0;
`endif

  logic       tck = 1'b0;
  logic       trst_n, tap_reset, tdi;
  logic       capture_ir, shift_ir, update_ir;
  logic       capture_dr, shift_dr, update_dr;
  logic       sel, user_tdo;
  logic       tdo;
  logic [3:0] instr;
  logic       bypass_sel, idcode_sel, user_sel;

  typedef struct {
    logic [3:0] op;
    logic       exp_bypass;
    logic       exp_idcode;
    logic       exp_user;
  } dec_vec_t;

  dec_vec_t dec_tbl[6];
  logic     exp_q[$];
  int       checks   = 0;
  int       failures = 0;

  jtag_ir_dr_path dut (
    .tck        (tck),
    .trst       (trst_n),
    .reset      (tap_reset),
    .tdi        (tdi),
    .captureIR  (capture_ir),
    .shiftIR    (shift_ir),
    .updateIR   (update_ir),
    .captureDR  (capture_dr),
    .shiftDR    (shift_dr),
    .updateDR   (update_dr),
    .select     (sel),
    .user_tdo   (user_tdo),
    .tdo        (tdo),
    .instr      (instr),
    .bypass_sel (bypass_sel),
    .idcode_sel (idcode_sel),
    .user_sel   (user_sel)
  );

  always #5 tck = ~tck;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One tck period, entered just after a posedge; TDO is sampled just after the negedge.
  task automatic applyStimulus(input string name, input logic cir, input logic sir, input logic uir,
                               input logic cdr, input logic sdr, input logic din,
                               input logic chk, input logic exp_bit);
    capture_ir = cir;
    shift_ir   = sir;
    update_ir  = uir;
    capture_dr = cdr;
    shift_dr   = sdr;
    tdi        = din;
    if (chk)
      exp_q.push_back(exp_bit);
    @(negedge tck);
    #1;
    if (chk)
      checkOutput(name, 32'(tdo), 32'(exp_q.pop_front()));
    @(posedge tck);
    #1;
  endtask

  task automatic loadIr(input logic [3:0] op);
    logic [3:0] cap;
    cap = 4'b0001;
    sel = 1'b1;
    applyStimulus("ir_capture", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus("ir_shift_out", 0, 1, 0, 0, 0, op[i], 1, cap[i]);
    applyStimulus("ir_update", 0, 0, 1, 0, 0, 0, 0, 0);
    sel = 1'b0;
  endtask

  task automatic checkDecode(input string name, input logic [3:0] exp_instr,
                             input logic eb, input logic ei, input logic eu);
    checkOutput({name, "_instr"}, 32'(instr), 32'(exp_instr));
    checkOutput({name, "_sels"}, 32'({bypass_sel, idcode_sel, user_sel}), 32'({eb, ei, eu}));
  endtask

  initial begin
    logic [31:0] pat;
    logic [3:0]  bp_tdi;
    logic [3:0]  bp_exp;
    logic [2:0]  ut;
    logic        e;

    dec_tbl[0] = '{4'h5, 1'b1, 1'b0, 1'b0};
    dec_tbl[1] = '{4'h8, 1'b0, 1'b0, 1'b1};
    dec_tbl[2] = '{4'h1, !HAS_ID, HAS_ID, 1'b0};
    dec_tbl[3] = '{4'hF, 1'b1, 1'b0, 1'b0};
    dec_tbl[4] = '{4'h0, 1'b1, 1'b0, 1'b0};
    dec_tbl[5] = '{4'h9, 1'b1, 1'b0, 1'b0};

    trst_n = 1'b0; tap_reset = 1'b1; tdi = 1'b0; sel = 1'b0; user_tdo = 1'b0;
    capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;

    // Power-on reset: TDO clears on the negedge, IR/DR on the posedge.
    @(negedge tck);
    #1;
    checkOutput("reset_tdo", 32'(tdo), 32'h0);
    @(posedge tck);
    #1;
    checkDecode("reset", RST_INSTR, !HAS_ID, HAS_ID, 1'b0);
    trst_n = 1'b1;

    // DR scan straight after reset: IDCODE when built, else a one-bit BYPASS lag.
    pat = 32'hA5C3_0F96;
    sel = 1'b0;
    applyStimulus("dr_capture", 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 36; i++) begin
      e = HAS_ID ? ((i < 32) ? IDCODE_VAL[i] : pat[i-32])
                 : ((i == 0) ? 1'b0 : pat[(i-1) % 32]);
      applyStimulus("reset_dr_scan", 0, 0, 0, 0, 1, pat[i % 32], 1, e);
    end

    // IR load of all-ones; an idle cycle before update must hold TDO.
    sel = 1'b1;
    applyStimulus("ir_capture", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus("ir_load_f", 0, 1, 0, 0, 0, 1, 1, (i == 0));
    applyStimulus("ir_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("tdo_hold", 32'(tdo), 32'h0);
    applyStimulus("ir_update", 0, 0, 1, 0, 0, 0, 0, 0);
    checkDecode("load_f", 4'hF, 1'b1, 1'b0, 1'b0);

    // BYPASS one-bit lag; updateDR must not disturb it.
    sel = 1'b0;
    bp_tdi = 4'b1101;
    bp_exp = 4'b1010;
    applyStimulus("bypass_capture", 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus("bypass_stream", 0, 0, 0, 0, 1, bp_tdi[i], 1, bp_exp[i]);
    update_dr = 1'b1;
    applyStimulus("bypass_update", 0, 0, 0, 0, 0, 0, 0, 0);
    update_dr = 1'b0;
    applyStimulus("bypass_after_update", 0, 0, 0, 0, 1, 0, 1, 1'b1);

    // Decode table.
    for (int k = 0; k < 6; k++) begin
      loadIr(dec_tbl[k].op);
      checkDecode($sformatf("decode_%0h", dec_tbl[k].op), dec_tbl[k].op,
                  dec_tbl[k].exp_bypass, dec_tbl[k].exp_idcode, dec_tbl[k].exp_user);
    end

    // USER DR routes user_tdo through the TDO register.
    loadIr(4'h8);
    sel = 1'b0;
    ut = 3'b101;
    for (int i = 0; i < 3; i++) begin
      user_tdo = ut[i];
      applyStimulus("user_stream", 0, 0, 0, 0, 1, 1, 1, ut[i]);
    end
    user_tdo = 1'b0;

    // TAP reset mid IR shift, with forced shift+update in the same cycle.
    sel = 1'b1;
    applyStimulus("ir_capture", 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("midrst_shift", 0, 1, 0, 0, 0, 0, 1, 1'b1);
    applyStimulus("midrst_shift", 0, 1, 0, 0, 0, 0, 1, 1'b0);
    tap_reset = 1'b0;
    applyStimulus("midrst_reset", 0, 1, 1, 0, 0, 0, 0, 0);
    tap_reset = 1'b1;
    checkDecode("midrst", RST_INSTR, !HAS_ID, HAS_ID, 1'b0);
    applyStimulus("midrst_update", 0, 0, 1, 0, 0, 0, 0, 0);
    checkDecode("midrst_upd", RST_INSTR, !HAS_ID, HAS_ID, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus("midrst_ir_out", 0, 1, 0, 0, 0, 0, 1, RST_INSTR[i]);

    // trst later in the run clears TDO and the instruction again.
    loadIr(4'h8);
    checkOutput("pre_trst_instr", 32'(instr), 32'h8);
    trst_n = 1'b0;
    @(negedge tck);
    #1;
    checkOutput("trst_tdo", 32'(tdo), 32'h0);
    @(posedge tck);
    #1;
    trst_n = 1'b1;
    checkDecode("trst", RST_INSTR, !HAS_ID, HAS_ID, 1'b0);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
